mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 6 +
 rtl/mem_array.sv | 19 +
 rtl/mem_responder.sv | 70 +++++++
 tb/tb_mem_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state encoding for the memory responder.
package mem_pkg;
  localparam int ADR_W = 12;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, WAITING = 2'd1, RESP = 2'd2} stateT;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port DEPTH x 16 array, synchronous write, registered read.
module mem_array import mem_pkg::*; #(
  parameter int DEPTH = 4096
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  assign idx = AW'(32'(adr) % DEPTH);
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wrData;
    rdData <= mem[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory slave with WAIT wait states.
// Optional MEM_ADDR_CHECK_EN flags latched addresses >= DEPTH via err.
module mem_responder import mem_pkg::*; #(
  parameter int WAIT = 2,
  parameter int DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADR_W-1:0]  memAdr,
  input  logic [DATA_W-1:0] memWriteData,
  output logic [DATA_W-1:0] memData,
  output logic              ack,
  output logic              busy,
  output logic              err
);
  stateT state, nextState;
  logic [3:0] cnt;
  logic weLat, curWe, inRange, enterResp;
  logic [ADR_W-1:0] adrLat, curAdr;
  logic [DATA_W-1:0] wdLat, curWd, rdData;
  // In IDLE the live inputs are used so WAIT=0 can commit on the accepting edge.
  assign curWe = state == IDLE ? we : weLat;
  assign curAdr = state == IDLE ? memAdr : adrLat;
  assign curWd = state == IDLE ? memWriteData : wdLat;
  assign enterResp = nextState == RESP && state != RESP;
  assign busy = state != IDLE;
`ifdef MEM_ADDR_CHECK_EN
  assign inRange = 32'(curAdr) < DEPTH;
`else
  assign inRange = 1'b1;
`endif
  always_comb begin
    nextState = state == IDLE ? (req ? (WAIT == 0 ? RESP : WAITING) : IDLE) :
                state == WAITING ? (cnt == 4'd1 ? RESP : WAITING) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      weLat <= 1'b0;
      adrLat <= '0;
      wdLat <= '0;
      ack <= 1'b0;
      err <= 1'b0;
      memData <= '0;
    end else begin
      ack <= state == RESP;
      err <= state == RESP && !inRange;
      if (state == RESP) memData <= !inRange ? '0 : weLat ? wdLat : rdData;
      if (state == IDLE && req) begin
        cnt <= 4'(WAIT);
        weLat <= we;
        adrLat <= memAdr;
        wdLat <= memWriteData;
      end else if (state == WAITING) cnt <= cnt - 4'd1;
    end
  end
  mem_array #(.DEPTH(DEPTH)) uArray (
    .clk(clk),
    .we(enterResp && curWe && inRange),
    .adr(curAdr),
    .wrData(curWd),
    .rdData(rdData)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven + scoreboard bench; u0 has WAIT=2/DEPTH=4096, u1 has WAIT=0/DEPTH=1024.
module tb_mem_responder;
  typedef struct {
    logic [15:0] d;
    logic        e;
    int          c;
  } expT;
  typedef struct {
    int          dut;
    logic        w;
    logic [11:0] a;
    logic [15:0] wd;
    logic [15:0] ed;
  } vecT;
`ifdef MEM_ADDR_CHECK_EN
  localparam logic [15:0] RC_D = 16'h0000;
  localparam logic        RC_E = 1'b1;
  localparam logic [15:0] RC_R = 16'h0001;
`else
  localparam logic [15:0] RC_D = 16'h7777;
  localparam logic        RC_E = 1'b0;
  localparam logic [15:0] RC_R = 16'h7777;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req[2], we[2], ack[2], busy[2], err[2];
  logic [11:0] adr[2];
  logic [15:0] wd[2], data[2];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  expT q[2][$];
  vecT tbl[12];
  logic [11:0] b2bA[3];
  logic [15:0] b2bD[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.WAIT(2), .DEPTH(4096)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .memAdr(adr[0]),
    .memWriteData(wd[0]), .memData(data[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0])
  );
  mem_responder #(.WAIT(0), .DEPTH(1024)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .memAdr(adr[1]),
    .memWriteData(wd[1]), .memData(data[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1])
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic tick();
    expT e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (ack[i] === 1'b1) begin
        if (q[i].size() == 0) chk($sformatf("unexpected_ack_dut%0d", i), 1, 0);
        else begin
          e = q[i].pop_front();
          chk($sformatf("data_dut%0d", i), 32'(data[i]), 32'(e.d));
          chk($sformatf("err_dut%0d", i), 32'(err[i]), 32'(e.e));
          chk($sformatf("latency_dut%0d", i), cyc, e.c);
        end
      end
    end
  endtask

  task automatic drain(input int i);
    for (int t = 0; t < 40 && q[i].size() != 0; t++) tick();
    chk($sformatf("ack_timeout_dut%0d", i), q[i].size(), 0);
    q[i].delete();
  endtask

  task automatic doTx(input int i, input logic w, input logic [11:0] a, input logic [15:0] d,
                      input logic [15:0] ed, input logic ee);
    req[i] = 1'b1;
    we[i] = w;
    adr[i] = a;
    wd[i] = d;
    q[i].push_back('{ed, ee, cyc + (i == 0 ? 2 : 0) + 2});
    tick();
    chk($sformatf("busy_after_accept_dut%0d", i), 32'(busy[i]), 1);
    req[i] = 1'b0;
    drain(i);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wd[i] = '0;
    end
    tbl = '{'{0, 1'b1, 12'h010, 16'hBEEF, 16'hBEEF}, '{0, 1'b0, 12'h010, 16'h0000, 16'hBEEF},
            '{0, 1'b1, 12'hFFF, 16'h1111, 16'h1111}, '{0, 1'b0, 12'hFFF, 16'h0000, 16'h1111},
            '{0, 1'b1, 12'h020, 16'h5A5A, 16'h5A5A}, '{0, 1'b1, 12'h011, 16'hA0A0, 16'hA0A0},
            '{0, 1'b0, 12'h010, 16'h0000, 16'hBEEF}, '{0, 1'b0, 12'h011, 16'h0000, 16'hA0A0},
            '{1, 1'b1, 12'h000, 16'h0001, 16'h0001}, '{1, 1'b1, 12'h001, 16'h0002, 16'h0002},
            '{1, 1'b1, 12'h3FF, 16'h0003, 16'h0003}, '{1, 1'b0, 12'h3FF, 16'h0000, 16'h0003}};
    b2bA = '{12'h000, 12'h001, 12'h3FF};
    b2bD = '{16'h0001, 16'h0002, 16'h0003};
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ack_dut%0d", i), 32'(ack[i]), 0);
      chk($sformatf("rst_busy_dut%0d", i), 32'(busy[i]), 0);
      chk($sformatf("rst_err_dut%0d", i), 32'(err[i]), 0);
      chk($sformatf("rst_data_dut%0d", i), 32'(data[i]), 0);
    end
    rst = 1'b0;
    tick();
    foreach (tbl[k]) begin
      doTx(tbl[k].dut, tbl[k].w, tbl[k].a, tbl[k].wd, tbl[k].ed, 1'b0);
      chk($sformatf("hold_vec%0d", k), 32'(data[tbl[k].dut]), 32'(tbl[k].ed));
    end
    // abort a write in WAITING: no ack, no array update
    req[0] = 1'b1; we[0] = 1'b1; adr[0] = 12'h020; wd[0] = 16'h1234;
    tick();
    chk("abort_busy_waiting", 32'(busy[0]), 1);
    req[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy_async", 32'(busy[0]), 0);
    chk("abort_data_async", 32'(data[0]), 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("abort_no_ack", 32'(ack[0]), 0);
    doTx(0, 1'b0, 12'h020, 16'h0000, 16'h5A5A, 1'b0);
    // request and address changes while WAITING must be ignored
    req[0] = 1'b1; we[0] = 1'b0; adr[0] = 12'h010;
    q[0].push_back('{16'hBEEF, 1'b0, cyc + 4});
    tick();
    req[0] = 1'b1; we[0] = 1'b1; adr[0] = 12'hFFF; wd[0] = 16'hDEAD;
    tick();
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    drain(0);
    doTx(0, 1'b0, 12'hFFF, 16'h0000, 16'h1111, 1'b0);
    // WAIT=0 with req held: ack every second cycle, busy low only in ack cycles
    req[1] = 1'b1; we[1] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      adr[1] = b2bA[j];
      q[1].push_back('{b2bD[j], 1'b0, cyc + 2});
      tick();
      chk($sformatf("b2b_busy%0d", j), 32'(busy[1]), 1);
      if (j == 2) req[1] = 1'b0;
      tick();
      chk($sformatf("b2b_gap%0d", j), 32'(busy[1]), 0);
    end
    drain(1);
    doTx(1, 1'b1, 12'h400, 16'h7777, RC_D, RC_E);
    doTx(1, 1'b0, 12'h000, 16'h0000, RC_R, 1'b0);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
